sram_queue_scheduler: RTL and testbench

SRAM_QUEUE_SCHEDULER -- requirements
Module: sram_queue_scheduler

---
 rtl/sram_queue_scheduler_pkg.sv | 14 +
 rtl/sram_queue_scheduler_rr_arbiter.sv | 25 ++
 rtl/sram_queue_scheduler.sv | 149 ++++++++++++++
 tb/tb_sram_queue_scheduler.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_queue_scheduler_pkg.sv
// Shared constants and state encoding for the SRAM queue scheduler.
package sram_queue_scheduler_pkg;
  localparam int DEF_NUM_QUEUES       = 4;
  localparam int DEF_QUEUE_ID_WIDTH   = 2;
  localparam int DEF_MEM_ADDR_WIDTH   = 19;
  localparam int DEF_QUEUE_ADDR_WIDTH = 17;
  localparam int QUEUE_SIZE           = 2 ** DEF_QUEUE_ADDR_WIDTH;

  typedef enum logic [1:0] {
    CAL_WAIT = 2'd0,
    ARB      = 2'd1,
    ISSUE    = 2'd2
  } sched_state_e;
endpackage

// File: rtl/sram_queue_scheduler_rr_arbiter.sv
// Round-robin arbiter: first requester after the last-granted index wins.
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id
);
  logic [IDW-1:0] idx;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    idx    = '0;
    for (int i = 1; i <= N; i++) begin
      idx = IDW'((int'(last) + i) % N);
      if (gnt == '0 && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end
endmodule

// File: rtl/sram_queue_scheduler.sv
// Arbitrates per-queue write/read requests into single SRAM commands and
// tracks head/tail pointers and occupancy of each SRAM-resident queue.
module sram_queue_scheduler
  import sram_queue_scheduler_pkg::*;
#(
  parameter int NUM_QUEUES       = DEF_NUM_QUEUES,
  parameter int QUEUE_ID_WIDTH   = DEF_QUEUE_ID_WIDTH,
  parameter int MEM_ADDR_WIDTH   = DEF_MEM_ADDR_WIDTH,
  parameter int QUEUE_ADDR_WIDTH = DEF_QUEUE_ADDR_WIDTH
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       cal_done,
  input  logic [NUM_QUEUES-1:0]                      wr_req,
  input  logic [NUM_QUEUES-1:0]                      rd_req,
  output logic [NUM_QUEUES-1:0]                      wr_grant,
  output logic [NUM_QUEUES-1:0]                      rd_grant,
  output logic                                       mem_cmd_valid,
  input  logic                                       mem_cmd_ready,
  output logic                                       mem_cmd_write,
  output logic [MEM_ADDR_WIDTH-1:0]                  mem_cmd_addr,
  output logic [QUEUE_ID_WIDTH-1:0]                  mem_cmd_qid,
  output logic [NUM_QUEUES-1:0]                      q_empty,
  output logic [NUM_QUEUES-1:0]                      q_full,
  output logic [NUM_QUEUES*(QUEUE_ADDR_WIDTH+1)-1:0] q_count
);
  localparam int CW    = QUEUE_ADDR_WIDTH + 1;
  localparam int QSIZE = 2 ** QUEUE_ADDR_WIDTH;

  sched_state_e state_q, state_d;
  logic [NUM_QUEUES-1:0][QUEUE_ADDR_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [NUM_QUEUES-1:0][CW-1:0]               count_q, count_d;
  logic [NUM_QUEUES-1:0]                       empty_q, empty_d, full_q, full_d;
  logic                                        valid_q, valid_d, write_q, write_d;
  logic [MEM_ADDR_WIDTH-1:0]                   addr_q, addr_d;
  logic [QUEUE_ID_WIDTH-1:0]                   qid_q, qid_d;
  logic [QUEUE_ID_WIDTH-1:0]                   wr_last_q, wr_last_d, rd_last_q, rd_last_d;
  logic                                        last_wr_q, last_wr_d;

  logic [NUM_QUEUES-1:0]     wr_elig, rd_elig, wr_oh, rd_oh;
  logic [QUEUE_ID_WIDTH-1:0] wr_id, rd_id, sel_id;
  logic                      pick_wr, accept;

  assign wr_elig = wr_req & ~full_q;
  assign rd_elig = rd_req & ~empty_q;

  rr_arbiter #(.N(NUM_QUEUES), .IDW(QUEUE_ID_WIDTH)) u_wr_arb (
    .req(wr_elig), .last(wr_last_q), .gnt(wr_oh), .gnt_id(wr_id));
  rr_arbiter #(.N(NUM_QUEUES), .IDW(QUEUE_ID_WIDTH)) u_rd_arb (
    .req(rd_elig), .last(rd_last_q), .gnt(rd_oh), .gnt_id(rd_id));

  // Both directions eligible: alternate against the last accepted command.
  assign pick_wr = (|wr_oh) && (!(|rd_oh) || !last_wr_q);
  assign sel_id  = pick_wr ? wr_id : rd_id;
  assign accept  = (state_q == ISSUE) && mem_cmd_ready;

  always_comb begin
    state_d   = state_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    valid_d   = valid_q;
    write_d   = write_q;
    addr_d    = addr_q;
    qid_d     = qid_q;
    wr_last_d = wr_last_q;
    rd_last_d = rd_last_q;
    last_wr_d = last_wr_q;
    empty_d   = empty_q;
    full_d    = full_q;
    case (state_q)
      CAL_WAIT: if (cal_done) state_d = ARB;
      ARB: begin
        if (!cal_done) state_d = CAL_WAIT;
        else if ((|wr_oh) || (|rd_oh)) begin
          state_d = ISSUE;
          valid_d = 1'b1;
          write_d = pick_wr;
          qid_d   = sel_id;
          addr_d  = MEM_ADDR_WIDTH'({sel_id, pick_wr ? tail_q[wr_id] : head_q[rd_id]});
        end
      end
      ISSUE: begin
        if (accept) begin
          valid_d   = 1'b0;
          state_d   = cal_done ? ARB : CAL_WAIT;
          last_wr_d = write_q;
          if (write_q) begin
            wr_last_d      = qid_q;
            tail_d[qid_q]  = tail_q[qid_q] + QUEUE_ADDR_WIDTH'(1);
            count_d[qid_q] = count_q[qid_q] + CW'(1);
          end else begin
            rd_last_d      = qid_q;
            head_d[qid_q]  = head_q[qid_q] + QUEUE_ADDR_WIDTH'(1);
            count_d[qid_q] = count_q[qid_q] - CW'(1);
          end
        end
      end
      default: state_d = CAL_WAIT;
    endcase
    for (int q = 0; q < NUM_QUEUES; q++) begin
      empty_d[q] = (count_d[q] == '0);
      full_d[q]  = (count_d[q] == CW'(QSIZE));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CAL_WAIT;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      empty_q   <= '1;
      full_q    <= '0;
      valid_q   <= 1'b0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      qid_q     <= '0;
      wr_last_q <= QUEUE_ID_WIDTH'(NUM_QUEUES - 1);
      rd_last_q <= QUEUE_ID_WIDTH'(NUM_QUEUES - 1);
      last_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
      valid_q   <= valid_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      qid_q     <= qid_d;
      wr_last_q <= wr_last_d;
      rd_last_q <= rd_last_d;
      last_wr_q <= last_wr_d;
    end
  end

  // Grants are gated by reset so a command dropped by reset is never granted.
  assign wr_grant      = (accept && !reset && write_q)  ? (NUM_QUEUES'(1) << qid_q) : '0;
  assign rd_grant      = (accept && !reset && !write_q) ? (NUM_QUEUES'(1) << qid_q) : '0;
  assign mem_cmd_valid = valid_q;
  assign mem_cmd_write = write_q;
  assign mem_cmd_addr  = addr_q;
  assign mem_cmd_qid   = qid_q;
  assign q_empty       = empty_q;
  assign q_full        = full_q;
  assign q_count       = count_q;
endmodule

// File: tb/tb_sram_queue_scheduler.sv
// Directed bench: default-size instance plus a small-queue instance for full/wrap cases.
module tb_sram_queue_scheduler;
  logic        clk = 1'b0;
  logic        reset, cal_done;
  logic [3:0]  wr_req, rd_req, wr_grant, rd_grant, q_empty, q_full;
  logic        mem_cmd_valid, mem_cmd_ready, mem_cmd_write;
  logic [18:0] mem_cmd_addr;
  logic [1:0]  mem_cmd_qid;
  logic [71:0] q_count;

  logic [3:0]  s_wr_req, s_rd_req, s_wr_grant, s_rd_grant, s_q_empty, s_q_full;
  logic        s_valid, s_ready, s_write;
  logic [4:0]  s_addr;
  logic [1:0]  s_qid;
  logic [15:0] s_q_count;

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sram_queue_scheduler dut (
    .clk(clk), .reset(reset), .cal_done(cal_done), .wr_req(wr_req), .rd_req(rd_req),
    .wr_grant(wr_grant), .rd_grant(rd_grant), .mem_cmd_valid(mem_cmd_valid),
    .mem_cmd_ready(mem_cmd_ready), .mem_cmd_write(mem_cmd_write), .mem_cmd_addr(mem_cmd_addr),
    .mem_cmd_qid(mem_cmd_qid), .q_empty(q_empty), .q_full(q_full), .q_count(q_count));

  sram_queue_scheduler #(.NUM_QUEUES(4), .QUEUE_ID_WIDTH(2), .MEM_ADDR_WIDTH(5),
                         .QUEUE_ADDR_WIDTH(3)) dut_s (
    .clk(clk), .reset(reset), .cal_done(cal_done), .wr_req(s_wr_req), .rd_req(s_rd_req),
    .wr_grant(s_wr_grant), .rd_grant(s_rd_grant), .mem_cmd_valid(s_valid),
    .mem_cmd_ready(s_ready), .mem_cmd_write(s_write), .mem_cmd_addr(s_addr),
    .mem_cmd_qid(s_qid), .q_empty(s_q_empty), .q_full(s_q_full), .q_count(s_q_count));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 20 && !mem_cmd_valid; i++) tick();
    check("cmd_valid", mem_cmd_valid, 1);
  endtask

  task automatic get_cmd(output logic w, output logic [18:0] a, output logic [3:0] wg,
                         output logic [3:0] rg, output int waits);
    waits = 0;
    while (!mem_cmd_valid && waits < 20) begin
      tick();
      waits++;
    end
    check("cmd_valid", mem_cmd_valid, 1);
    w  = mem_cmd_write;
    a  = mem_cmd_addr;
    wg = wr_grant;
    rg = rd_grant;
    tick();
  endtask

  task automatic s_get_cmd(output logic w, output logic [4:0] a, output logic [3:0] wg,
                           output logic [3:0] rg);
    for (int i = 0; i < 20 && !s_valid; i++) tick();
    check("s_cmd_valid", s_valid, 1);
    w  = s_write;
    a  = s_addr;
    wg = s_wr_grant;
    rg = s_rd_grant;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        w;
    logic [18:0] a;
    logic [4:0]  sa;
    logic [3:0]  wg, rg;
    int          waits;
    logic [3:0]  exp_wg [5]  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [18:0] exp_a  [5]  = '{19'h00000, 19'h20000, 19'h40000, 19'h60000, 19'h00001};
    logic        alt_w  [4]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [18:0] alt_a  [4]  = '{19'h20004, 19'h20001, 19'h20005, 19'h20002};
    logic [17:0] alt_c  [4]  = '{18'd4, 18'd3, 18'd4, 18'd3};

    cal_done = 0; wr_req = 0; rd_req = 0; mem_cmd_ready = 0;
    s_wr_req = 0; s_rd_req = 0; s_ready = 0;
    do_reset();

    check("rst_valid", mem_cmd_valid, 0);
    check("rst_write", mem_cmd_write, 0);
    check("rst_addr", mem_cmd_addr, 0);
    check("rst_qid", mem_cmd_qid, 0);
    check("rst_empty", q_empty, 4'b1111);
    check("rst_full", q_full, 4'b0000);
    check("rst_count", q_count, 72'd0);
    check("rst_grants", {wr_grant, rd_grant}, 8'h00);

    // calibration gate and first write
    wr_req = 4'b0001; mem_cmd_ready = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("cal_wait_valid", mem_cmd_valid, 0);
    end
    cal_done = 1;
    tick();
    check("cal_arb_valid", mem_cmd_valid, 0);
    tick();
    check("first_valid", mem_cmd_valid, 1);
    check("first_write", mem_cmd_write, 1);
    check("first_addr", mem_cmd_addr, 19'h00000);
    check("first_wgrant", wr_grant, 4'b0001);
    wr_req = 0;
    tick();
    check("first_count0", q_count[17:0], 18'd1);
    check("first_empty", q_empty, 4'b1110);
    check("first_gnt_pulse", wr_grant, 4'b0000);

    // round-robin writes across all queues
    do_reset();
    wr_req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      get_cmd(w, a, wg, rg, waits);
      check("rr_wgrant", wg, exp_wg[i]);
      check("rr_addr", a, exp_a[i]);
      if (i > 0) check("rr_rate", waits, 1);
    end
    wr_req = 0;
    check("rr_count0", q_count[17:0], 18'd2);
    check("rr_count3", q_count[71:54], 18'd1);

    // read/write alternation on queue 1
    do_reset();
    wr_req = 4'b0010;
    for (int i = 0; i < 4; i++) get_cmd(w, a, wg, rg, waits);
    wr_req = 0; rd_req = 4'b0010;
    get_cmd(w, a, wg, rg, waits);
    check("alt_pre_read", w, 0);
    check("alt_pre_addr", a, 19'h20000);
    check("alt_pre_rgrant", rg, 4'b0010);
    wr_req = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      get_cmd(w, a, wg, rg, waits);
      check("alt_dir", w, alt_w[i]);
      check("alt_addr", a, alt_a[i]);
      check("alt_count1", q_count[35:18], alt_c[i]);
    end
    wr_req = 0; rd_req = 0;

    // ready stall with request dropped mid-issue
    do_reset();
    mem_cmd_ready = 0; wr_req = 4'b0100;
    wait_valid();
    wr_req = 0;
    for (int i = 0; i < 5; i++) begin
      check("stall_addr", mem_cmd_addr, 19'h40000);
      check("stall_write", mem_cmd_write, 1);
      check("stall_qid", mem_cmd_qid, 2'd2);
      check("stall_nogrant", wr_grant, 4'b0000);
      tick();
    end
    mem_cmd_ready = 1;
    #1;
    check("stall_grant", wr_grant, 4'b0100);
    tick();
    check("stall_gnt_pulse", wr_grant, 4'b0000);
    check("stall_valid_drop", mem_cmd_valid, 0);
    check("stall_count2", q_count[53:36], 18'd1);

    // calibration loss during issue: command completes, then idle, pointers kept
    mem_cmd_ready = 0; wr_req = 4'b0100;
    wait_valid();
    wr_req = 0; cal_done = 0;
    tick();
    check("calfall_hold", mem_cmd_valid, 1);
    mem_cmd_ready = 1;
    #1;
    check("calfall_grant", wr_grant, 4'b0100);
    tick();
    wr_req = 4'b0100;
    for (int i = 0; i < 3; i++) tick();
    check("calfall_idle", mem_cmd_valid, 0);
    check("calfall_count2", q_count[53:36], 18'd2);
    cal_done = 1;
    get_cmd(w, a, wg, rg, waits);
    check("calfall_ptr", a, 19'h40002);
    wr_req = 0;

    // reset while a command is pending
    do_reset();
    mem_cmd_ready = 0; wr_req = 4'b0001;
    wait_valid();
    reset = 1; mem_cmd_ready = 1;
    #1;
    check("rst_issue_grant", wr_grant, 4'b0000);
    tick();
    check("rst_issue_valid", mem_cmd_valid, 0);
    tick();
    reset = 0; wr_req = 0;
    check("rst_issue_count", q_count[17:0], 18'd0);

    // small instance: queue 2 fills to capacity
    do_reset();
    s_ready = 1; s_wr_req = 4'b0100;
    for (int i = 0; i < 8; i++) s_get_cmd(w, sa, wg, rg);
    check("full_flag", s_q_full, 4'b0100);
    check("full_count2", s_q_count[11:8], 4'd8);
    for (int i = 0; i < 4; i++) begin
      check("full_no_cmd", s_valid, 0);
      check("full_no_grant", s_wr_grant, 4'b0000);
      tick();
    end
    s_rd_req = 4'b0100;
    s_get_cmd(w, sa, wg, rg);
    check("full_read_dir", w, 0);
    check("full_read_addr", sa, 5'b10000);
    check("full_read_rgrant", rg, 4'b0100);
    check("full_clear", s_q_full, 4'b0000);
    s_rd_req = 0; s_wr_req = 0;

    // small instance: tail pointer wrap on queue 0
    do_reset();
    s_wr_req = 4'b0001;
    for (int i = 0; i < 7; i++) s_get_cmd(w, sa, wg, rg);
    check("wrap_pre_addr", sa, 5'd6);
    s_wr_req = 0; s_rd_req = 4'b0001;
    s_get_cmd(w, sa, wg, rg);
    s_rd_req = 0; s_wr_req = 4'b0001;
    s_get_cmd(w, sa, wg, rg);
    check("wrap_last_addr", sa, 5'd7);
    check("wrap_last_wgrant", wg, 4'b0001);
    s_get_cmd(w, sa, wg, rg);
    s_wr_req = 0;
    check("wrap_first_addr", sa, 5'd0);
    check("wrap_first_dir", w, 1);
    check("wrap_count0", s_q_count[3:0], 4'd8);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
